sync_dual_port_ram: RTL and testbench

Parametrised synchronous simple-dual-port RAM: one write port and one independent read port sharing a single clock. It replaces the asynchronous bidirectional single-port memory in the lab memory subsystem, giving registered read data with a `rvalid` strobe, selectable read-during-write behaviour, an optional extra output pipeline stage, and a hardware init sweep that clears every location after reset.

---
 rtl/sync_dual_port_ram.sv | 115 +++++++++++
 tb/tb_sync_dual_port_ram.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sync_dual_port_ram.sv
// Simple-dual-port synchronous RAM: one write port, one read port, one clock.
// A post-reset sweep loads INIT_VAL everywhere before requests are accepted.
module sync_dual_port_ram #(
  parameter int              WIDTH    = 16,
  parameter int              DEPTH    = 8,
  parameter int              ADDRESS  = 3,
  parameter int              RD_MODE  = 0,
  parameter int              OUT_REG  = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDRESS-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               re,
  input  logic [ADDRESS-1:0] raddr,
  output logic [WIDTH-1:0]   rdata,
  output logic               rvalid,
  output logic               rerr,
  output logic               werr,
  output logic               ready
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDRESS:0]   DEPTH_A = (ADDRESS+1)'(DEPTH);
  localparam logic [ADDRESS-1:0] LAST    = ADDRESS'(DEPTH - 1);

  state_t             state, state_nx;
  logic [ADDRESS-1:0] ptr;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               run, wr_ok, wr_bad, rd_acc, rd_oor;
  logic [WIDTH-1:0]   rd_word;
  logic               s_valid, s_err;
  logic [WIDTH-1:0]   s_data;

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == S_INIT && ptr == LAST) state_nx = S_RUN;
  end

  always_comb begin
    run     = (state == S_RUN);
    ready   = run;
    wr_ok   = run && we && ({1'b0, waddr} < DEPTH_A);
    wr_bad  = run && we && !({1'b0, waddr} < DEPTH_A);
    rd_acc  = run && re;
    rd_oor  = !({1'b0, raddr} < DEPTH_A);
    rd_word = '0;
    // Write-first bypass only on a genuine same-address collision.
    if (!rd_oor)
      rd_word = (RD_MODE == 1 && wr_ok && waddr == raddr) ? wdata : mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst)                  ptr <= '0;
    else if (state == S_INIT) ptr <= ptr + ADDRESS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) mem[ptr]   <= INIT_VAL;
      else if (wr_ok)      mem[waddr] <= wdata;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_pipe
      logic             p_valid, p_err;
      logic [WIDTH-1:0] p_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          p_valid <= 1'b0;
          p_err   <= 1'b0;
          p_data  <= '0;
        end else begin
          p_valid <= rd_acc;
          p_err   <= rd_acc && rd_oor;
          if (rd_acc) p_data <= rd_word;
        end
      end

      assign s_valid = p_valid;
      assign s_err   = p_err;
      assign s_data  = p_data;
    end else begin : g_direct
      assign s_valid = rd_acc;
      assign s_err   = rd_acc && rd_oor;
      assign s_data  = rd_word;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rerr   <= 1'b0;
      werr   <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= s_valid;
      rerr   <= s_err;
      werr   <= wr_bad;
      if (s_valid) rdata <= s_data;
    end
  end

endmodule

// File: tb/tb_sync_dual_port_ram.sv
// Directed bench for sync_dual_port_ram: three configurations driven in lockstep
// (default / write-first+pipelined+A5A5 init / DEPTH=6) against hand-derived values.
module tb_sync_dual_port_ram;

  logic        clk = 1'b0;
  logic        rst, rst2, we, re;
  logic [2:0]  waddr, raddr;
  logic [15:0] wdata;

  logic [15:0] rd  [3];
  logic        rv  [3];
  logic        rer [3];
  logic        wer [3];
  logic        rdy [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_dual_port_ram #(.WIDTH(16), .DEPTH(8), .ADDRESS(3), .RD_MODE(0), .OUT_REG(0),
                       .INIT_VAL(16'h0000)) u0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rd[0]), .rvalid(rv[0]), .rerr(rer[0]), .werr(wer[0]), .ready(rdy[0]));

  sync_dual_port_ram #(.WIDTH(16), .DEPTH(8), .ADDRESS(3), .RD_MODE(1), .OUT_REG(1),
                       .INIT_VAL(16'hA5A5)) u1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rd[1]), .rvalid(rv[1]), .rerr(rer[1]), .werr(wer[1]), .ready(rdy[1]));

  sync_dual_port_ram #(.WIDTH(16), .DEPTH(6), .ADDRESS(3), .RD_MODE(0), .OUT_REG(0),
                       .INIT_VAL(16'h0000)) u2 (
    .clk(clk), .rst(rst2), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rd[2]), .rvalid(rv[2]), .rerr(rer[2]), .werr(wer[2]), .ready(rdy[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rd(input int k, input string tag, input logic v,
                          input logic [15:0] d, input logic e);
    check($sformatf("%s_u%0d_rvalid", tag, k), 32'(rv[k]),  32'(v));
    check($sformatf("%s_u%0d_rerr", tag, k),   32'(rer[k]), 32'(e));
    check($sformatf("%s_u%0d_rdata", tag, k),  32'(rd[k]),  32'(d));
  endtask

  task automatic check_quiet(input string tag, input logic exp_rdy);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_u%0d_ready", tag, k),  32'(rdy[k]), 32'(exp_rdy));
      check($sformatf("%s_u%0d_rvalid", tag, k), 32'(rv[k]),  32'(0));
      check($sformatf("%s_u%0d_rerr", tag, k),   32'(rer[k]), 32'(0));
      check($sformatf("%s_u%0d_werr", tag, k),   32'(wer[k]), 32'(0));
    end
  endtask

  function automatic logic [15:0] expv(input int k, input int a, input bit written);
    if (k == 2 && a >= 6) return 16'h0000;
    if (written)          return 16'h1000 + 16'(a);
    return (k == 1) ? 16'hA5A5 : 16'h0000;
  endfunction

  // Reads 0..7 back-to-back then idles two cycles; u1 lags one cycle.
  task automatic read_all(input string tag, input bit written, input logic [15:0] prev1);
    for (int i = 0; i < 10; i++) begin
      re    = (i < 8);
      raddr = 3'(i);
      tick();
      if (i < 8) check_rd(0, tag, 1'b1, expv(0, i, written), 1'b0);
      else       check_rd(0, tag, 1'b0, expv(0, 7, written), 1'b0);
      if (i == 0)      check_rd(1, tag, 1'b0, prev1, 1'b0);
      else if (i <= 8) check_rd(1, tag, 1'b1, expv(1, i - 1, written), 1'b0);
      else             check_rd(1, tag, 1'b0, expv(1, 7, written), 1'b0);
      if (i < 8) check_rd(2, tag, 1'b1, expv(2, i, written), i >= 6);
      else       check_rd(2, tag, 1'b0, 16'h0000, 1'b0);
    end
    re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    we = 1'b1; re = 1'b1; wdata = 16'hFFFF; waddr = '0; raddr = '0;

    for (int c = 0; c < 2; c++) begin
      tick();
      check_quiet("reset", 1'b0);
      for (int k = 0; k < 3; k++) check($sformatf("reset_u%0d_rdata", k), 32'(rd[k]), 32'(0));
    end

    // Sweep with requests held high; u2 (6 deep) released two edges later.
    rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      if (t == 3) rst2 = 1'b0;
      waddr = 3'(t - 1);
      raddr = 3'(8 - t);
      tick();
      check_quiet("init", t == 8);
    end
    we = 1'b0; re = 1'b0;
    read_all("initrd", 1'b0, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 16'h1000 + 16'(i);
      tick();
      check("wr_u0_werr", 32'(wer[0]), 32'(0));
      check("wr_u1_werr", 32'(wer[1]), 32'(0));
      check("wr_u2_werr", 32'(wer[2]), 32'(i >= 6));
    end
    we = 1'b0;
    tick();
    check("wr_u2_werr_end", 32'(wer[2]), 32'(0));
    read_all("wrrd", 1'b1, 16'hA5A5);

    we = 1'b1; waddr = 3'd3; wdata = 16'h1111; re = 1'b0;
    tick();
    check("col_pre_u0_rvalid", 32'(rv[0]), 32'(0));
    re = 1'b1; raddr = 3'd3; wdata = 16'h2222;
    tick();
    check_rd(0, "col", 1'b1, 16'h1111, 1'b0);
    check_rd(1, "col", 1'b0, 16'h1007, 1'b0);
    check_rd(2, "col", 1'b1, 16'h1111, 1'b0);
    we = 1'b0;
    tick();
    check_rd(0, "colnext", 1'b1, 16'h2222, 1'b0);
    check_rd(1, "colnext", 1'b1, 16'h2222, 1'b0);
    check_rd(2, "colnext", 1'b1, 16'h2222, 1'b0);
    re = 1'b0;
    tick();
    check_rd(0, "colidle", 1'b0, 16'h2222, 1'b0);
    check_rd(1, "colidle", 1'b1, 16'h2222, 1'b0);
    tick();
    check_rd(1, "colidle2", 1'b0, 16'h2222, 1'b0);

    re = 1'b1; raddr = 3'd0;
    tick();
    check_rd(0, "flight", 1'b1, 16'h1000, 1'b0);
    check_rd(1, "flight", 1'b0, 16'h2222, 1'b0);
    rst = 1'b1; rst2 = 1'b1; re = 1'b0;
    tick();
    check_quiet("flrst", 1'b0);
    for (int k = 0; k < 3; k++) check($sformatf("flrst_u%0d_rdata", k), 32'(rd[k]), 32'(0));
    rst = 1'b0; rst2 = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check_quiet("flpost", 1'b0);
    end

    rst = 1'b1; rst2 = 1'b1;
    tick();
    check_quiet("midrst", 1'b0);
    rst = 1'b0; rst2 = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("restart_u0_ready", 32'(rdy[0]), 32'(t == 8));
      check("restart_u1_ready", 32'(rdy[1]), 32'(t == 8));
      check("restart_u2_ready", 32'(rdy[2]), 32'(t >= 6));
      check("restart_u1_rvalid", 32'(rv[1]), 32'(0));
    end
    read_all("rstrd", 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
